// File: rtl/expr_checker.sv
// Streaming recogniser for ASCII infix arithmetic expressions.
// Consumes one character per in_valid_i cycle and flags whether the prefix
// seen so far forms a complete, well-formed expression.
module expr_checker #(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned MAX_DEPTH  = 4,
    parameter int unsigned DEPTH_W    = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk_i,
    input  logic               clr_ni,
    input  logic               restart_i,
    input  logic               in_valid_i,
    input  logic [7:0]         in_i,
    output logic               out_o,
    output logic               err_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic [CNT_W-1:0]   op_count_o
);

    localparam int unsigned DcntW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        StOpnd,
        StNum,
        StAfter,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic [DcntW-1:0]   dcnt_q, dcnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;

    logic is_dig, is_op, is_lp, is_rp, is_sp;
    logic [CNT_W-1:0] cnt_inc;
    logic depth_at_max, depth_zero;

    // Classify the incoming character; anything unmatched is treated as bad.
    always_comb begin
        is_dig = (in_i >= 8'h30) && (in_i <= 8'h39);
        is_op  = (in_i == 8'h2B) || (in_i == 8'h2D) || (in_i == 8'h2A) || (in_i == 8'h2F);
        is_lp  = (in_i == 8'h28);
        is_rp  = (in_i == 8'h29);
        is_sp  = (in_i == 8'h20);
    end

    // Saturating operator increment and depth boundary flags.
    always_comb begin
        cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        depth_at_max = (depth_q == DEPTH_W'(MAX_DEPTH));
        depth_zero   = (depth_q == '0);
    end

    // Next-state logic; restart takes priority and discards the character.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (restart_i) begin
            state_d = StOpnd;
            dcnt_d  = '0;
            depth_d = '0;
            cnt_d   = '0;
            out_d   = 1'b0;
        end else if (in_valid_i) begin
            unique case (state_q)
                StOpnd: begin
                    if (is_dig) begin
                        state_d = StNum;
                        dcnt_d  = DcntW'(1);
                    end else if (is_lp) begin
                        if (depth_at_max) state_d = StErr;
                        else              depth_d = depth_q + DEPTH_W'(1);
                    end else if (!is_sp) begin
                        state_d = StErr;
                    end
                end
                StNum: begin
                    if (is_dig) begin
                        if (dcnt_q == DcntW'(MAX_DIGITS)) state_d = StErr;
                        else                              dcnt_d  = dcnt_q + DcntW'(1);
                    end else if (is_op) begin
                        state_d = StOpnd;
                        cnt_d   = cnt_inc;
                    end else if (is_rp) begin
                        if (depth_zero) begin
                            state_d = StErr;
                        end else begin
                            state_d = StAfter;
                            depth_d = depth_q - DEPTH_W'(1);
                        end
                    end else if (is_sp) begin
                        state_d = StAfter;
                    end else begin
                        state_d = StErr;
                    end
                end
                StAfter: begin
                    if (is_op) begin
                        state_d = StOpnd;
                        cnt_d   = cnt_inc;
                    end else if (is_rp) begin
                        if (depth_zero) state_d = StErr;
                        else            depth_d = depth_q - DEPTH_W'(1);
                    end else if (!is_sp) begin
                        state_d = StErr;
                    end
                end
                StErr: begin
                    // Dead state: every character is absorbed.
                end
                default: state_d = StErr;
            endcase
            out_d = ((state_d == StNum) || (state_d == StAfter)) && (depth_d == '0);
        end
    end

    // State and status registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q <= StOpnd;
            dcnt_q  <= '0;
            depth_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out_o      = out_q;
    assign err_o      = (state_q == StErr);
    assign depth_o    = depth_q;
    assign op_count_o = cnt_q;

endmodule

// File: tb/tb_expr_checker.sv
// Self-checking bench for expr_checker: directed scenarios plus random
// character streams compared against a grammar-level reference model.
module tb_expr_checker;

    localparam int MaxDigits = 3;
    localparam int MaxDepth  = 4;
    localparam int CntMax    = 255;

    logic       clk;
    logic       clr_n;
    logic       restart;
    logic       in_valid;
    logic [7:0] in_ch;
    logic       out_w;
    logic       err_w;
    logic [2:0] depth_w;
    logic [7:0] op_count_w;

    int total = 0;
    int bad   = 0;

    // Reference model: grammar position, not state encoding.
    int m_depth;
    int m_ops;
    int m_digits;   // digits of the number currently being read, 0 if none
    bit m_expect;   // an operand is required next
    bit m_dead;
    bit m_out;

    expr_checker #(
        .MAX_DIGITS(3),
        .MAX_DEPTH (4),
        .DEPTH_W   (3),
        .CNT_W     (8)
    ) dut (
        .clk_i     (clk),
        .clr_ni    (clr_n),
        .restart_i (restart),
        .in_valid_i(in_valid),
        .in_i      (in_ch),
        .out_o     (out_w),
        .err_o     (err_w),
        .depth_o   (depth_w),
        .op_count_o(op_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_depth  = 0;
        m_ops    = 0;
        m_digits = 0;
        m_expect = 1'b1;
        m_dead   = 1'b0;
        m_out    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] c);
        bit dig, op, lp, rp, sp, die;
        if (m_dead) return;
        dig = (c >= "0") && (c <= "9");
        op  = (c == "+") || (c == "-") || (c == "*") || (c == "/");
        lp  = (c == "(");
        rp  = (c == ")");
        sp  = (c == " ");
        die = 1'b0;
        if (m_expect) begin
            if (dig) begin
                m_expect = 1'b0;
                m_digits = 1;
            end else if (lp) begin
                if (m_depth == MaxDepth) die = 1'b1;
                else m_depth++;
            end else if (!sp) begin
                die = 1'b1;
            end
        end else begin
            if (dig) begin
                if (m_digits > 0 && m_digits < MaxDigits) m_digits++;
                else die = 1'b1;
            end else if (op) begin
                m_ops    = (m_ops < CntMax) ? m_ops + 1 : CntMax;
                m_expect = 1'b1;
                m_digits = 0;
            end else if (rp) begin
                if (m_depth == 0) die = 1'b1;
                else begin
                    m_depth--;
                    m_digits = 0;
                end
            end else if (sp) begin
                m_digits = 0;
            end else begin
                die = 1'b1;
            end
        end
        if (die) begin
            m_dead = 1'b1;
            m_out  = 1'b0;
        end else begin
            m_out = !m_expect && (m_depth == 0);
        end
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, " out"}, 32'(out_w), 32'(m_out));
        check_eq({tag, " err"}, 32'(err_w), 32'(m_dead));
        check_eq({tag, " depth"}, 32'(depth_w), 32'(m_depth));
        check_eq({tag, " ops"}, 32'(op_count_w), 32'(m_ops));
    endtask

    task automatic send(input logic [7:0] c, input string tag);
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b1;
        in_ch    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_step(c);
        check_model(tag);
    endtask

    task automatic idle(input logic [7:0] c, input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_ch    = c;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_restart(input logic with_valid, input logic [7:0] c, input string tag);
        @(negedge clk);
        restart  = 1'b1;
        in_valid = with_valid;
        in_ch    = c;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check_model(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], tag);
    endtask

    string pool = "0123456789+-*/(() )12+x";

    initial begin
        logic [7:0] ch;
        bit exp_out[5];
        int exp_dep[8];
        string s1;
        string s2;

        clr_n    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_ch    = 8'h00;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        clr_n = 1'b1;

        // 1+2*3: out toggles 1,0,1,0,1
        exp_out = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        s1 = "1+2*3";
        for (int i = 0; i < 5; i++) begin
            send(s1[i], "plan1");
            check_eq("plan1 out const", 32'(out_w), 32'(exp_out[i]));
        end
        check_eq("plan1 ops const", 32'(op_count_w), 32'd2);
        check_eq("plan1 err const", 32'(err_w), 32'd0);

        // ((45)-6): depth trace, out only at the end
        do_restart(1'b0, 8'h00, "rst2");
        exp_dep = '{1, 2, 2, 2, 1, 1, 1, 0};
        s2 = "((45)-6)";
        for (int i = 0; i < 8; i++) begin
            send(s2[i], "plan2");
            check_eq("plan2 depth const", 32'(depth_w), 32'(exp_dep[i]));
            check_eq("plan2 out const", 32'(out_w), (i == 7) ? 32'd1 : 32'd0);
        end

        // Too many digits, then absorbed operator
        do_restart(1'b0, 8'h00, "rst3");
        send_str("123", "plan3");
        send("4", "plan3 4th");
        check_eq("digits err const", 32'(err_w), 32'd1);
        check_eq("digits out const", 32'(out_w), 32'd0);
        send("+", "plan3 absorb");
        check_eq("absorb ops const", 32'(op_count_w), 32'd0);

        // Nesting overflow
        do_restart(1'b0, 8'h00, "rst4");
        send_str("((((", "plan4");
        check_eq("nest4 err const", 32'(err_w), 32'd0);
        send("(", "plan4 5th");
        check_eq("nest5 err const", 32'(err_w), 32'd1);
        check_eq("nest5 depth const", 32'(depth_w), 32'd4);

        // Space splits numbers; stray close paren
        do_restart(1'b0, 8'h00, "rst5");
        send_str("7 ", "plan5");
        check_eq("7sp out const", 32'(out_w), 32'd1);
        send("8", "plan5 8");
        check_eq("7sp8 err const", 32'(err_w), 32'd1);
        do_restart(1'b0, 8'h00, "rst6");
        send(")", "plan6");
        check_eq("rp err const", 32'(err_w), 32'd1);
        check_eq("rp depth const", 32'(depth_w), 32'd0);

        // Restart beats in_valid; character dropped
        do_restart(1'b1, "9", "restart+valid");
        check_eq("restart err const", 32'(err_w), 32'd0);
        check_eq("restart out const", 32'(out_w), 32'd0);
        send("9", "after restart");
        check_eq("after restart out const", 32'(out_w), 32'd1);

        // Asynchronous clear between edges
        do_restart(1'b0, 8'h00, "rst7");
        send_str("(1+", "plan7");
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_model("async clr");
        check_eq("async depth const", 32'(depth_w), 32'd0);
        check_eq("async ops const", 32'(op_count_w), 32'd0);
        #1;
        clr_n = 1'b1;

        // Idle cycles ignore in
        send_str(" 42", "plan8");
        for (int i = 0; i < 6; i++) idle(8'(pool[i % pool.len()]), "idle");

        // Operator counter saturation
        do_restart(1'b0, 8'h00, "rst9");
        for (int i = 0; i < 300; i++) begin
            send("1", "sat");
            send("+", "sat");
        end
        check_eq("sat ops const", 32'(op_count_w), 32'd255);
        check_eq("sat err const", 32'(err_w), 32'd0);

        // Random streams
        for (int n = 0; n < 60; n++) begin
            int len;
            do_restart(1'b0, 8'h00, "rnd restart");
            len = int'($urandom_range(1, 24));
            for (int k = 0; k < len; k++) begin
                int r;
                r  = int'($urandom_range(0, 99));
                ch = 8'(pool[$urandom_range(0, pool.len() - 1)]);
                if (r < 8) idle(ch, "rnd idle");
                else if (r < 10) do_restart(1'b1, ch, "rnd restart+valid");
                else send(ch, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
